// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree: op encodings,
// per-op padding identity, and the stage-placement rule.
package reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Value that leaves a reduction unchanged: 1 for AND-like ops, 0 otherwise.
  function automatic logic identity(input logic [1:0] op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  // Op applied inside the tree; NAND reduces as AND and is inverted at the root.
  function automatic logic [1:0] base_op(input logic [1:0] op);
    return (op == OP_NAND) ? OP_AND : op;
  endfunction

  // A register follows every lps-th tree level, and always the root level.
  function automatic bit is_reg_level(input int lvl, input int lps, input int depth);
    return (lvl != 0) && (((lvl % lps) == 0) || (lvl == depth));
  endfunction

endpackage

// File: rtl/reduce2.sv
// Two-input reduction cell. NAND is never seen here as a distinct
// operation: it is treated as AND, with inversion left to the root.
module reduce2
  import reduce_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  // Combine the two children with the selected base operation.
  always_comb begin
    y = a & b;
    case (op)
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/reduce_pipe.sv
// Pipelined N-input 1-bit reduction (AND/OR/XOR/NAND).
// Level 0 holds the padded operand; each tree level l halves the width.
// A register stage follows every LPS levels and the root level, so y and
// out_valid always come straight from flops.
//
// Handshake: a beat moves on the input side when in_valid && in_ready and on
// the output side when out_valid && out_ready. All stages advance together
// when advance = !out_valid || out_ready; in_ready is exactly advance, so a
// stalled output freezes the whole pipe and an idle advance loads a bubble.
module reduce_pipe
  import reduce_pkg::*;
#(
  parameter int N   = 8,
  parameter int LPS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic [1:0]   op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         y,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int D = $clog2(N);
  localparam int P = 1 << D;

  if (N < 2) begin : g_bad_n
    $error("reduce_pipe: N must be at least 2");
  end
  if (LPS < 1) begin : g_bad_lps
    $error("reduce_pipe: LPS must be at least 1");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int W = P >> l;

    // Node values handed to the next level, and the beat's valid bit.
    logic [W-1:0] q;
    logic         vld;

    // The beat's op travels alongside its data up to the level below the root.
    if (l < D) begin : g_op
      logic [1:0] opv;
      if (l == 0) begin : g_src
        assign opv = op;
      end else if (is_reg_level(l, LPS, D)) begin : g_reg
        // Capture the op with its data so later op changes cannot touch it.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            opv <= 2'b00;
          end else if (advance) begin
            opv <= g_lvl[l-1].g_op.opv;
          end
        end
      end else begin : g_thru
        assign opv = g_lvl[l-1].g_op.opv;
      end
    end

    if (l == 0) begin : g_leaf
      // Real inputs at the low leaves, the op's identity in the padding leaves.
      for (genvar i = 0; i < P; i++) begin : g_bit
        if (i < N) begin : g_in
          assign q[i] = in[i];
        end else begin : g_pad
          assign q[i] = identity(op);
        end
      end
      assign vld = in_valid;
    end else begin : g_int
      logic [1:0]   op_in;
      logic [W-1:0] c;
      logic [W-1:0] nv;

      assign op_in = g_lvl[l-1].g_op.opv;

      for (genvar j = 0; j < W; j++) begin : g_cell
        reduce2 u_cell (
          .a  (g_lvl[l-1].q[2*j]),
          .b  (g_lvl[l-1].q[2*j+1]),
          .op (base_op(op_in)),
          .y  (c[j])
        );
      end

      if (l == D) begin : g_root
        // NAND is the AND tree inverted once, right before the output flop.
        assign nv = (op_in == OP_NAND) ? ~c : c;
      end else begin : g_mid
        assign nv = c;
      end

      if (is_reg_level(l, LPS, D)) begin : g_reg
        // Stage register: loads on advance, holds while the output is stalled.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
          end else if (advance) begin
            q   <= nv;
            vld <= g_lvl[l-1].vld;
          end
        end
      end else begin : g_thru
        assign q   = nv;
        assign vld = g_lvl[l-1].vld;
      end
    end
  end

  assign y         = g_lvl[D].q[0];
  assign out_valid = g_lvl[D].vld;

endmodule

// File: tb/tb_reduce_pipe.sv
// Directed bench for reduce_pipe: three instances (N=8/LPS=1, N=5/LPS=2,
// N=2/LPS=4) sharing clock and reset, driven from one linear sequence.
module tb_reduce_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [7:0] in8;
  logic [4:0] in5;
  logic [1:0] in2;
  logic [1:0] dop [3];
  logic       dvalid [3];
  logic       dready [3];
  logic [2:0] rdy;
  logic [2:0] yv;
  logic [2:0] ov;

  logic [0:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  reduce_pipe #(.N(8), .LPS(1)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .op(dop[0]), .in_valid(dvalid[0]),
    .in_ready(rdy[0]), .y(yv[0]), .out_valid(ov[0]), .out_ready(dready[0])
  );

  reduce_pipe #(.N(5), .LPS(2)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in(in5), .op(dop[1]), .in_valid(dvalid[1]),
    .in_ready(rdy[1]), .y(yv[1]), .out_valid(ov[1]), .out_ready(dready[1])
  );

  reduce_pipe #(.N(2), .LPS(4)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .op(dop[2]), .in_valid(dvalid[2]),
    .in_ready(rdy[2]), .y(yv[2]), .out_valid(ov[2]), .out_ready(dready[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Golden reduction over the low n bits.
  function automatic logic ref_red(input logic [7:0] v, input int n, input logic [1:0] o);
    logic r;
    r = (o == 2'b00) || (o == 2'b11);
    for (int i = 0; i < n; i++) begin
      case (o)
        2'b00, 2'b11: r = r & v[i];
        2'b01:        r = r | v[i];
        default:      r = r ^ v[i];
      endcase
    end
    if (o == 2'b11) r = ~r;
    return r;
  endfunction

  task automatic set_in(input int d, input logic [7:0] v);
    case (d)
      0:       in8 = v;
      1:       in5 = v[4:0];
      default: in2 = v[1:0];
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into instance d, measure latency to out_valid and the result.
  task automatic single_beat(input int d, input logic [7:0] v, input logic [1:0] o,
                             input logic ey, input int el, input string tag);
    int lat;
    lat = 0;
    chk({tag, "_in_ready"}, 32'(rdy[d]), 32'd1);
    set_in(d, v);
    dop[d] = o;
    dvalid[d] = 1'b1;
    do begin
      tick();
      // Scramble the inputs once the beat is taken; it must not care.
      dvalid[d] = 1'b0;
      set_in(d, ~v);
      dop[d] = ~o;
      lat++;
    end while (!ov[d] && lat < 8);
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_y"}, 32'(yv[d]), 32'(ey));
    tick();
    chk({tag, "_drained"}, 32'(ov[d]), 32'd0);
  endtask

  // driver / scoreboard sequence
  initial begin
    int got, first, last, acc;
    logic [7:0] v;
    logic [1:0] o;
    logic snap;

    in8 = '0; in5 = '0; in2 = '0;
    for (int d = 0; d < 3; d++) begin
      dop[d] = 2'b00; dvalid[d] = 1'b0; dready[d] = 1'b1;
    end

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_y", 32'(yv), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(rdy), 32'h7);
    chk("post_rst_out_valid", 32'(ov), 32'd0);

    // N=8, LPS=1: latency 3
    single_beat(0, 8'hFF, 2'b00, 1'b1, 3, "n8_and_ff");
    single_beat(0, 8'hFE, 2'b00, 1'b0, 3, "n8_and_fe");
    single_beat(0, 8'h00, 2'b01, 1'b0, 3, "n8_or_00");
    single_beat(0, 8'h80, 2'b01, 1'b1, 3, "n8_or_80");
    single_beat(0, 8'h07, 2'b10, 1'b1, 3, "n8_xor_07");
    single_beat(0, 8'h0F, 2'b10, 1'b0, 3, "n8_xor_0f");
    single_beat(0, 8'hFF, 2'b11, 1'b0, 3, "n8_nand_ff");
    single_beat(0, 8'h7F, 2'b11, 1'b1, 3, "n8_nand_7f");

    // N=5, LPS=2: latency 2, three padding leaves
    single_beat(1, 8'h16, 2'b10, 1'b1, 2, "n5_xor_16");
    single_beat(1, 8'h00, 2'b01, 1'b0, 2, "n5_or_00");
    single_beat(1, 8'h1F, 2'b11, 1'b0, 2, "n5_nand_1f");
    single_beat(1, 8'h0F, 2'b11, 1'b1, 2, "n5_nand_0f");
    single_beat(1, 8'h1F, 2'b00, 1'b1, 2, "n5_and_1f");

    // N=2, LPS=4: latency 1
    single_beat(2, 8'h01, 2'b01, 1'b1, 1, "n2_or_01");
    single_beat(2, 8'h02, 2'b00, 1'b0, 1, "n2_and_10");
    single_beat(2, 8'h03, 2'b10, 1'b0, 1, "n2_xor_11");
    single_beat(2, 8'h01, 2'b10, 1'b1, 1, "n2_xor_01");

    // 16 back-to-back beats, one result per cycle in order
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 16) begin
        v = 8'($urandom_range(0, 255));
        o = 2'($urandom_range(0, 3));
        in8 = v; dop[0] = o; dvalid[0] = 1'b1;
        exp_q.push_back(ref_red(v, 8, o));
      end else begin
        dvalid[0] = 1'b0;
      end
      tick();
      if (ov[0]) begin
        if (first < 0) first = c;
        last = c;
        got++;
        if (exp_q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else chk("stream_y", 32'(yv[0]), 32'(exp_q.pop_front()));
      end
    end
    chk("stream_count", 32'(got), 32'd16);
    chk("stream_span", 32'(last - first + 1), 32'd16);

    // backpressure: fill the pipe with out_ready low
    exp_q.delete();
    dready[0] = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      v = 8'($urandom_range(0, 255));
      o = 2'(c);
      in8 = v; dop[0] = o; dvalid[0] = 1'b1;
      if (rdy[0]) begin
        exp_q.push_back(ref_red(v, 8, o));
        acc++;
      end
      tick();
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    snap = yv[0];
    chk("bp_head_y", 32'(snap), 32'(exp_q[0]));
    for (int c = 0; c < 5; c++) begin
      in8 = 8'($urandom_range(0, 255));
      tick();
      chk("bp_in_ready", 32'(rdy[0]), 32'd0);
      chk("bp_out_valid", 32'(ov[0]), 32'd1);
      chk("bp_y_hold", 32'(yv[0]), 32'(snap));
    end
    dvalid[0] = 1'b0;
    dready[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (ov[0]) begin
        got++;
        if (exp_q.size() == 0) chk("bp_extra", 32'd1, 32'd0);
        else chk("bp_drain_y", 32'(yv[0]), 32'(exp_q.pop_front()));
      end
      tick();
    end
    chk("bp_drain_count", 32'(got), 32'd3);

    // reset with three beats in flight
    for (int c = 0; c < 3; c++) begin
      in8 = 8'hFF; dop[0] = 2'b00; dvalid[0] = 1'b1;
      tick();
    end
    dvalid[0] = 1'b0;
    chk("inflight_out_valid", 32'(ov[0]), 32'd1);
    chk("inflight_y", 32'(yv[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov), 32'd0);
    chk("midrst_y", 32'(yv), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ov != 3'b000) got++;
    end
    chk("stale_beats", 32'(got), 32'd0);
    single_beat(0, 8'h55, 2'b10, 1'b0, 3, "post_rst_beat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
